// File: rtl/ocp_bus_master.sv
// ocp_bus_master: single-outstanding OCP initiator.
//
// Converts a valid/ready client request into one OCP command (MCmd/MAddr/MData/MByteEn).
// It holds the command until the slave sets SCmdAccept. It then returns a one-cycle completion
// pulse carrying read data, or an error flag for a FAIL/ERR response.
//
// Optional feature macro: OCP_MASTER_TIMEOUT_EN
//   When defined, a 16-bit watchdog aborts a command or response wait after TIMEOUT cycles and
//   reports err=1. When undefined, the block waits indefinitely.
//
// Ports
//   clk, nrst                      clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      client request handshake
//   i_req_write/addr/data/ben      request payload
//   o_rsp_valid/data/err           completion pulse, read data, error flag
//   o_MCmd/MAddr/MData/MByteEn     OCP master request outputs
//   i_SCmdAccept, i_SData, i_SResp OCP slave accept, read data, response

module ocp_bus_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BEN_WIDTH  = 4
`ifdef OCP_MASTER_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT    = 16'd255
`endif
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic [BEN_WIDTH-1:0]  i_req_ben,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            mcmd_q, mcmd_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic [BEN_WIDTH-1:0]  mben_q, mben_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_c;

`ifdef OCP_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Expiry fires on the cycle in which the count would reach TIMEOUT.
    assign timeout_c = (16'(cnt_q + 16'd1) == TIMEOUT);

    // Restart on every new wait phase; count while waiting on the slave.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_CMD && state_q != S_CMD) ||
            (state_q == S_CMD && state_d == S_RESP)) begin
            cnt_d = 16'd0;
        end else if (state_q == S_CMD || state_q == S_RESP) begin
            cnt_d = 16'(cnt_q + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        mcmd_d      = mcmd_q;
        maddr_d     = maddr_q;
        mdata_d     = mdata_q;
        mben_d      = mben_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (i_req_valid && ready_q) begin
                    state_d = S_CMD;
                    mcmd_d  = i_req_write ? OCP_CMD_WRITE : OCP_CMD_READ;
                    maddr_d = i_req_addr;
                    mdata_d = i_req_write ? i_req_data : '0;
                    mben_d  = i_req_ben;
                    ready_d = 1'b0;
                end
            end

            S_CMD: begin
                if (i_SCmdAccept) begin
                    mcmd_d  = OCP_CMD_IDLE;
                    maddr_d = '0;
                    mdata_d = '0;
                    mben_d  = '0;
                    if (mcmd_q == OCP_CMD_WRITE) begin
                        // Posted write: complete on accept, SResp is not waited for.
                        state_d     = S_IDLE;
                        ready_d     = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                    end else if (i_SResp != OCP_RESP_NULL) begin
                        state_d     = S_IDLE;
                        ready_d     = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = (i_SResp == OCP_RESP_DVA) ? i_SData : '0;
                        rsp_err_d   = (i_SResp != OCP_RESP_DVA);
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (timeout_c) begin
                    mcmd_d      = OCP_CMD_IDLE;
                    maddr_d     = '0;
                    mdata_d     = '0;
                    mben_d      = '0;
                    state_d     = S_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end

            S_RESP: begin
                if (i_SResp != OCP_RESP_NULL) begin
                    state_d     = S_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (i_SResp == OCP_RESP_DVA) ? i_SData : '0;
                    rsp_err_d   = (i_SResp != OCP_RESP_DVA);
                end else if (timeout_c) begin
                    state_d     = S_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                mcmd_d  = OCP_CMD_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            mcmd_q      <= OCP_CMD_IDLE;
            maddr_q     <= '0;
            mdata_q     <= '0;
            mben_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcmd_q      <= mcmd_d;
            maddr_q     <= maddr_d;
            mdata_q     <= mdata_d;
            mben_q      <= mben_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_MCmd      = mcmd_q;
    assign o_MAddr     = maddr_q;
    assign o_MData     = mdata_q;
    assign o_MByteEn   = mben_q;

endmodule

// File: tb/tb_ocp_bus_master.sv
// Directed testbench for ocp_bus_master. The bench drives the slave side by hand. Inputs change
// and outputs are sampled on the falling clock edge.
// With OCP_MASTER_TIMEOUT_EN defined, the bench also runs the timeout case with TIMEOUT=8.

module tb_ocp_bus_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic          clk;
    logic          nrst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_data;
    logic [BW-1:0] i_req_ben;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic [AW-1:0] o_MAddr;
    logic [2:0]    o_MCmd;
    logic [DW-1:0] o_MData;
    logic [BW-1:0] o_MByteEn;
    logic          i_SCmdAccept;
    logic [DW-1:0] i_SData;
    logic [1:0]    i_SResp;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef OCP_MASTER_TIMEOUT_EN
    ocp_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEN_WIDTH(BW), .TIMEOUT(16'd8)) dut (
`else
    ocp_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEN_WIDTH(BW)) dut (
`endif
        .clk          (clk),
        .nrst         (nrst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_write  (i_req_write),
        .i_req_addr   (i_req_addr),
        .i_req_data   (i_req_data),
        .i_req_ben    (i_req_ben),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .o_MAddr      (o_MAddr),
        .o_MCmd       (o_MCmd),
        .o_MData      (o_MData),
        .o_MByteEn    (o_MByteEn),
        .i_SCmdAccept (i_SCmdAccept),
        .i_SData      (i_SData),
        .i_SResp      (i_SResp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] ben);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_data  = data;
        i_req_ben   = ben;
    endtask

    task automatic slave(input logic acc, input logic [1:0] resp, input logic [31:0] data);
        i_SCmdAccept = acc;
        i_SResp      = resp;
        i_SData      = data;
    endtask

    initial begin
        nrst = 1'b0;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_req_ben   = '0;
        slave(1'b0, 2'd0, 32'h0);
        step();
        step();
        check("rst_mcmd", 32'(o_MCmd), 32'd0);
        check("rst_maddr", o_MAddr, 32'h0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_data", o_rsp_data, 32'h0);
        nrst = 1'b1;
        step();
        check("rst_ready", 32'(o_req_ready), 32'd1);

        // Test 1: write 0x004 <- 0x10, then read it back.
        issue(1'b1, 32'h004, 32'h10, 4'hF);
        step();
        check("t1_wr_mcmd", 32'(o_MCmd), 32'd1);
        check("t1_wr_maddr", o_MAddr, 32'h004);
        check("t1_wr_mdata", o_MData, 32'h10);
        check("t1_wr_mben", 32'(o_MByteEn), 32'hF);
        check("t1_wr_ready", 32'(o_req_ready), 32'd0);
        i_req_valid = 1'b0;
        slave(1'b1, 2'd0, 32'h0);
        step();
        check("t1_wr_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t1_wr_rsp_err", 32'(o_rsp_err), 32'd0);
        check("t1_wr_rsp_data", o_rsp_data, 32'h0);
        check("t1_wr_mcmd_idle", 32'(o_MCmd), 32'd0);
        check("t1_wr_ready_back", 32'(o_req_ready), 32'd1);
        slave(1'b0, 2'd0, 32'h0);
        issue(1'b0, 32'h004, 32'h0, 4'hF);
        step();
        check("t1_rd_mcmd", 32'(o_MCmd), 32'd2);
        check("t1_rd_maddr", o_MAddr, 32'h004);
        i_req_valid = 1'b0;
        slave(1'b1, 2'd0, 32'h0);
        step();
        check("t1_rd_resp_wait", 32'(o_rsp_valid), 32'd0);
        check("t1_rd_mcmd_idle", 32'(o_MCmd), 32'd0);
        slave(1'b0, 2'd1, 32'h10);
        step();
        check("t1_rd_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t1_rd_rsp_data", o_rsp_data, 32'h10);
        check("t1_rd_rsp_err", 32'(o_rsp_err), 32'd0);
        check("t1_rd_ready", 32'(o_req_ready), 32'd1);
        slave(1'b0, 2'd0, 32'h0);
        step();
        check("t1_rd_pulse_end", 32'(o_rsp_valid), 32'd0);

        // Test 2: the slave holds SCmdAccept low for 5 cycles on a read of 0x000.
        issue(1'b0, 32'h000, 32'h0, 4'h3);
        step();
        i_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_mcmd", 32'(o_MCmd), 32'd2);
            check("t2_hold_maddr", o_MAddr, 32'h000);
            check("t2_hold_mben", 32'(o_MByteEn), 32'h3);
            check("t2_hold_no_rsp", 32'(o_rsp_valid), 32'd0);
            step();
        end
        check("t2_hold_last", 32'(o_MCmd), 32'd2);
        slave(1'b1, 2'd1, 32'hABCD);
        step();
        check("t2_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t2_rsp_data", o_rsp_data, 32'hABCD);
        slave(1'b0, 2'd0, 32'h0);
        step();
        check("t2_single_pulse", 32'(o_rsp_valid), 32'd0);

        // Test 3: ERR response; byte enable of zero passes through unmodified.
        issue(1'b0, 32'h00C, 32'h0, 4'h0);
        step();
        check("t3_mben_zero", 32'(o_MByteEn), 32'h0);
        i_req_valid = 1'b0;
        slave(1'b1, 2'd3, 32'hDEAD);
        step();
        check("t3_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t3_rsp_err", 32'(o_rsp_err), 32'd1);
        check("t3_rsp_data", o_rsp_data, 32'h0);
        check("t3_ready", 32'(o_req_ready), 32'd1);
        slave(1'b0, 2'd0, 32'h0);
        step();

        // Test 4: back-to-back requests with req_valid held. The payload change while busy is ignored.
        issue(1'b1, 32'h000, 32'h7, 4'hF);
        step();
        check("t4_wr_mcmd", 32'(o_MCmd), 32'd1);
        issue(1'b0, 32'h008, 32'h0, 4'hF);
        step();
        check("t4_busy_mcmd", 32'(o_MCmd), 32'd1);
        check("t4_busy_maddr", o_MAddr, 32'h000);
        check("t4_busy_mdata", o_MData, 32'h7);
        slave(1'b1, 2'd0, 32'h0);
        step();
        check("t4_wr_rsp", 32'(o_rsp_valid), 32'd1);
        check("t4_wr_ready", 32'(o_req_ready), 32'd1);
        slave(1'b0, 2'd0, 32'h0);
        step();
        check("t4_rd_mcmd", 32'(o_MCmd), 32'd2);
        check("t4_rd_maddr", o_MAddr, 32'h008);
        check("t4_rd_no_rsp", 32'(o_rsp_valid), 32'd0);
        i_req_valid = 1'b0;
        slave(1'b1, 2'd1, 32'h55);
        step();
        check("t4_rd_rsp", 32'(o_rsp_valid), 32'd1);
        check("t4_rd_data", o_rsp_data, 32'h55);
        slave(1'b0, 2'd0, 32'h0);
        step();

        // Test 5: reset asserted while waiting in RESP.
        issue(1'b0, 32'h004, 32'h0, 4'hF);
        step();
        i_req_valid = 1'b0;
        slave(1'b1, 2'd0, 32'h0);
        step();
        slave(1'b0, 2'd0, 32'h0);
        nrst = 1'b0;
        #1;
        check("t5_rst_mcmd", 32'(o_MCmd), 32'd0);
        check("t5_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("t5_rst_ready", 32'(o_req_ready), 32'd0);
        step();
        nrst = 1'b1;
        slave(1'b0, 2'd1, 32'h99);
        step();
        check("t5_ready", 32'(o_req_ready), 32'd1);
        check("t5_no_stale_rsp", 32'(o_rsp_valid), 32'd0);
        step();
        check("t5_no_stale_rsp2", 32'(o_rsp_valid), 32'd0);
        slave(1'b0, 2'd0, 32'h0);
        step();

`ifdef OCP_MASTER_TIMEOUT_EN
        // Test 6: the slave never accepts; the command aborts after 8 cycles in CMD.
        issue(1'b0, 32'h010, 32'h0, 4'hF);
        step();
        i_req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("t6_wait_mcmd", 32'(o_MCmd), 32'd2);
            check("t6_wait_no_rsp", 32'(o_rsp_valid), 32'd0);
            step();
        end
        check("t6_last_mcmd", 32'(o_MCmd), 32'd2);
        step();
        check("t6_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t6_rsp_err", 32'(o_rsp_err), 32'd1);
        check("t6_rsp_data", o_rsp_data, 32'h0);
        check("t6_mcmd_idle", 32'(o_MCmd), 32'd0);
        check("t6_ready", 32'(o_req_ready), 32'd1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
